sdram_burst_arbiter: RTL and testbench
======================================

Name: sdram_burst_arbiter

Overview:
- Shares the single application-side burst interface of top_sdram_controller between two client ports, each with independent read and write burst requests.
- Four request slots, served round-robin, one burst at a time.
- Forwards address, length and data for the granted slot and routes the handshake and finish pulses back to it.
- Sits between the clients (e.g. UART receive buffer, LED/status readback) and the SDRAM controller.

Parameters:
- APP_ADDR_WIDTH, 24, burst start address width ({bank,row,col} = 2+13+9).
- APP_BURST_WIDTH, 10, burst length width in words.
- SDR_DQ_WIDTH, 16, data word width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- p_wr_req  in  2  per-port write burst request, bit i = port i
- p_wr_addr  in  2*APP_ADDR_WIDTH  per-port write address, port i at slice i
- p_wr_len  in  2*APP_BURST_WIDTH  per-port write length
- p_wr_data  in  2*SDR_DQ_WIDTH  per-port write data
- p_wr_data_req  out  2  per-port write data strobe
- p_wr_finish  out  2  per-port write-done pulse
- p_rd_req  in  2  per-port read burst request
- p_rd_addr  in  2*APP_ADDR_WIDTH  per-port read address
- p_rd_len  in  2*APP_BURST_WIDTH  per-port read length
- p_rd_data  out  SDR_DQ_WIDTH  read data, broadcast to both ports
- p_rd_data_valid  out  2  per-port read-data valid
- p_rd_finish  out  2  per-port read-done pulse
- wr_burst_req / wr_burst_addr / wr_burst_len / wr_burst_data  out  1/AW/BW/DQ  to controller
- wr_burst_data_req, wr_burst_finish  in  1  from controller
- rd_burst_req / rd_burst_addr / rd_burst_len  out  1/AW/BW  to controller
- rd_burst_data  in  DQ; rd_burst_data_valid, rd_burst_finish  in  1  from controller
- grant  out  2  one-hot port currently owning the controller
- busy  out  1  high from ISSUE through GAP

Behaviour:
- Slots are indexed as 0=p0_wr, 1=p0_rd, 2=p1_wr, 3=p1_rd.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The priority pointer is set to 0, so slot 0 has highest priority.
  - Reset asserted mid-burst drops the controller request immediately; no finish pulse is generated.
- States: IDLE -> ISSUE -> WAIT -> GAP -> IDLE.
- IDLE:
  - Scan slots starting at the pointer; the first slot with its req high wins.
  - Latch the winner's slot index, address and length; go to ISSUE on the next edge.
  - If the latched length is 0, go to GAP instead, pulse that slot's finish for 1 cycle, and issue no controller request.
- ISSUE / WAIT:
  - Registered wr_burst_req or rd_burst_req is high, starting the cycle after the winner is sampled (1-cycle grant latency).
  - It is held until the matching controller finish is sampled.
  - ISSUE lasts 1 cycle, then WAIT.
- Routing during ISSUE/WAIT:
  - wr_burst_data = granted port's p_wr_data (combinational mux).
  - wr_burst_data_req -> p_wr_data_req[granted] only.
  - rd_burst_data_valid -> p_rd_data_valid[granted] only.
  - Finish pulses -> p_*_finish[granted] only, same cycle, combinational.
  - All other ports' strobes stay 0.
- On finish:
  - Controller request is low on the next edge; go to GAP.
  - Pointer = (served slot + 1) mod 4.
- GAP:
  - Exactly 1 cycle; no arbitration, so the client drops its req and the controller returns to idle.
  - Then IDLE.
- Finish of the wrong type (e.g. rd_burst_finish during a write grant) is ignored.
- Client contract: req, addr and len are held stable until its finish; req is dropped the cycle after finish.
- Simultaneous requests: priority rotates, so 4 continuously-requesting slots are each served once per 4 bursts.
- grant is one-hot of (slot>>1) during ISSUE..GAP, else 0.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, GAP);
  - NUM_SLOTS=4;
  - slot index constants.
- Sub-module rr_pick4: combinational rotating-priority picker; inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0].

Test Plan:
- p0_wr_req with addr 0x000100, len 8 -> wr_burst_req high 1 cycle later; 8 data_req strobes routed only to p0; p_wr_finish[0] pulses once; p1 strobes stay 0.
- p0_wr and p1_rd requested together, pointer 0 -> p0 write first; after GAP, p1 read at 0x010020, len 4; 4 p_rd_data_valid[1] pulses; grant sequence 01, then 10.
- All 4 slots held high for 8 bursts -> service order 0,1,2,3,0,1,2,3; exactly 1 GAP cycle between bursts.
- p1_wr with len 0 -> p_wr_finish[1] pulses 1 cycle after request; wr_burst_req never asserts.
- rst asserted during WAIT of a len-16 read -> controller request and all outputs 0 asynchronously; after release, pointer 0 and slot 0 wins.
- Spurious wr_burst_finish during a read grant -> ignored; read still completes on rd_burst_finish.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM burst arbiter.
// Slot numbering: bit 0 selects read/write, bit 1 selects the client port.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } arb_state_t;

    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_P0_WR = 2'd0;
    localparam logic [1:0] SLOT_P0_RD = 2'd1;
    localparam logic [1:0] SLOT_P1_WR = 2'd2;
    localparam logic [1:0] SLOT_P1_RD = 2'd3;

    function automatic logic slot_is_rd(input logic [1:0] slot);
        return slot[0];
    endfunction

    function automatic logic slot_port(input logic [1:0] slot);
        return slot[1];
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker over four request slots.
// The scan starts at ptr and wraps; the first asserted slot wins.
module rr_pick4
    import sdram_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            cand = ptr + 2'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Shares one SDRAM controller burst interface between two client ports,
// each with separate read and write requests, served round-robin one burst at a time.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int APP_ADDR_WIDTH  = 24,
    parameter int APP_BURST_WIDTH = 10,
    parameter int SDR_DQ_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   p_wr_req,
    input  logic [2*APP_ADDR_WIDTH-1:0]  p_wr_addr,
    input  logic [2*APP_BURST_WIDTH-1:0] p_wr_len,
    input  logic [2*SDR_DQ_WIDTH-1:0]    p_wr_data,
    output logic [1:0]                   p_wr_data_req,
    output logic [1:0]                   p_wr_finish,
    input  logic [1:0]                   p_rd_req,
    input  logic [2*APP_ADDR_WIDTH-1:0]  p_rd_addr,
    input  logic [2*APP_BURST_WIDTH-1:0] p_rd_len,
    output logic [SDR_DQ_WIDTH-1:0]      p_rd_data,
    output logic [1:0]                   p_rd_data_valid,
    output logic [1:0]                   p_rd_finish,
    output logic                         wr_burst_req,
    output logic [APP_ADDR_WIDTH-1:0]    wr_burst_addr,
    output logic [APP_BURST_WIDTH-1:0]   wr_burst_len,
    output logic [SDR_DQ_WIDTH-1:0]      wr_burst_data,
    input  logic                         wr_burst_data_req,
    input  logic                         wr_burst_finish,
    output logic                         rd_burst_req,
    output logic [APP_ADDR_WIDTH-1:0]    rd_burst_addr,
    output logic [APP_BURST_WIDTH-1:0]   rd_burst_len,
    input  logic [SDR_DQ_WIDTH-1:0]      rd_burst_data,
    input  logic                         rd_burst_data_valid,
    input  logic                         rd_burst_finish,
    output logic [1:0]                   grant,
    output logic                         busy
);

    arb_state_t                 state, state_nx;
    logic [1:0]                 slot_q, slot_nx;
    logic [1:0]                 ptr_q, ptr_nx;
    logic [APP_ADDR_WIDTH-1:0]  addr_q, addr_nx;
    logic [APP_BURST_WIDTH-1:0] len_q, len_nx;
    logic                       wr_req_q, wr_req_nx;
    logic                       rd_req_q, rd_req_nx;
    logic                       zfin_q, zfin_nx;

    logic [3:0]                 slot_req;
    logic                       pick_valid;
    logic [1:0]                 pick_idx;
    logic [APP_ADDR_WIDTH-1:0]  pick_addr;
    logic [APP_BURST_WIDTH-1:0] pick_len;
    logic                       fin_match;
    logic                       port;
    logic [1:0]                 port_oh;

    assign slot_req = {p_rd_req[1], p_wr_req[1], p_rd_req[0], p_wr_req[0]};

    rr_pick4 u_pick (
        .req   (slot_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        case (pick_idx)
            SLOT_P0_WR: begin
                pick_addr = p_wr_addr[APP_ADDR_WIDTH-1:0];
                pick_len  = p_wr_len[APP_BURST_WIDTH-1:0];
            end
            SLOT_P0_RD: begin
                pick_addr = p_rd_addr[APP_ADDR_WIDTH-1:0];
                pick_len  = p_rd_len[APP_BURST_WIDTH-1:0];
            end
            SLOT_P1_WR: begin
                pick_addr = p_wr_addr[2*APP_ADDR_WIDTH-1:APP_ADDR_WIDTH];
                pick_len  = p_wr_len[2*APP_BURST_WIDTH-1:APP_BURST_WIDTH];
            end
            default: begin
                pick_addr = p_rd_addr[2*APP_ADDR_WIDTH-1:APP_ADDR_WIDTH];
                pick_len  = p_rd_len[2*APP_BURST_WIDTH-1:APP_BURST_WIDTH];
            end
        endcase
    end

    // A finish of the other burst type never ends the current grant.
    assign fin_match = slot_is_rd(slot_q) ? rd_burst_finish : wr_burst_finish;

    always_comb begin
        state_nx  = state;
        slot_nx   = slot_q;
        ptr_nx    = ptr_q;
        addr_nx   = addr_q;
        len_nx    = len_q;
        wr_req_nx = wr_req_q;
        rd_req_nx = rd_req_q;
        zfin_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    slot_nx = pick_idx;
                    addr_nx = pick_addr;
                    len_nx  = pick_len;
                    // Zero-length bursts complete locally without touching the controller.
                    if (pick_len == '0) begin
                        state_nx = ST_GAP;
                        zfin_nx  = 1'b1;
                        ptr_nx   = pick_idx + 2'd1;
                    end else begin
                        state_nx  = ST_ISSUE;
                        wr_req_nx = !slot_is_rd(pick_idx);
                        rd_req_nx = slot_is_rd(pick_idx);
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                state_nx = ST_WAIT;
                if (fin_match) begin
                    state_nx  = ST_GAP;
                    wr_req_nx = 1'b0;
                    rd_req_nx = 1'b0;
                    ptr_nx    = slot_q + 2'd1;
                end
            end
            ST_GAP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot_q   <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            zfin_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            slot_q   <= slot_nx;
            ptr_q    <= ptr_nx;
            addr_q   <= addr_nx;
            len_q    <= len_nx;
            wr_req_q <= wr_req_nx;
            rd_req_q <= rd_req_nx;
            zfin_q   <= zfin_nx;
        end
    end

    assign port    = slot_port(slot_q);
    assign port_oh = port ? 2'b10 : 2'b01;

    assign busy  = (state != ST_IDLE);
    assign grant = busy ? port_oh : '0;

    assign wr_burst_req  = wr_req_q;
    assign wr_burst_addr = wr_req_q ? addr_q : '0;
    assign wr_burst_len  = wr_req_q ? len_q : '0;
    assign wr_burst_data = !wr_req_q ? '0 :
                           port ? p_wr_data[2*SDR_DQ_WIDTH-1:SDR_DQ_WIDTH]
                                : p_wr_data[SDR_DQ_WIDTH-1:0];

    assign rd_burst_req  = rd_req_q;
    assign rd_burst_addr = rd_req_q ? addr_q : '0;
    assign rd_burst_len  = rd_req_q ? len_q : '0;

    assign p_rd_data       = rd_req_q ? rd_burst_data : '0;
    assign p_wr_data_req   = (wr_req_q && wr_burst_data_req) ? port_oh : '0;
    assign p_rd_data_valid = (rd_req_q && rd_burst_data_valid) ? port_oh : '0;
    assign p_wr_finish     = ((wr_req_q && wr_burst_finish) || (zfin_q && !slot_is_rd(slot_q)))
                             ? port_oh : '0;
    assign p_rd_finish     = ((rd_req_q && rd_burst_finish) || (zfin_q && slot_is_rd(slot_q)))
                             ? port_oh : '0;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench: random clients and a random controller drive the arbiter,
// and a transaction-level model of the arbitration rules is compared every cycle.
module tb_sdram_burst_arbiter;

    localparam int AW = 24;
    localparam int BW = 10;
    localparam int DQ = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      p_wr_req, p_rd_req;
    logic [2*AW-1:0] p_wr_addr, p_rd_addr;
    logic [2*BW-1:0] p_wr_len, p_rd_len;
    logic [2*DQ-1:0] p_wr_data;
    logic [1:0]      p_wr_data_req, p_wr_finish, p_rd_data_valid, p_rd_finish;
    logic [DQ-1:0]   p_rd_data;
    logic            wr_burst_req, rd_burst_req;
    logic [AW-1:0]   wr_burst_addr, rd_burst_addr;
    logic [BW-1:0]   wr_burst_len, rd_burst_len;
    logic [DQ-1:0]   wr_burst_data, rd_burst_data;
    logic            wr_burst_data_req, wr_burst_finish;
    logic            rd_burst_data_valid, rd_burst_finish;
    logic [1:0]      grant;
    logic            busy;

    always #5 clk = ~clk;

    sdram_burst_arbiter #(
        .APP_ADDR_WIDTH  (AW),
        .APP_BURST_WIDTH (BW),
        .SDR_DQ_WIDTH    (DQ)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .p_wr_req            (p_wr_req),
        .p_wr_addr           (p_wr_addr),
        .p_wr_len            (p_wr_len),
        .p_wr_data           (p_wr_data),
        .p_wr_data_req       (p_wr_data_req),
        .p_wr_finish         (p_wr_finish),
        .p_rd_req            (p_rd_req),
        .p_rd_addr           (p_rd_addr),
        .p_rd_len            (p_rd_len),
        .p_rd_data           (p_rd_data),
        .p_rd_data_valid     (p_rd_data_valid),
        .p_rd_finish         (p_rd_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish),
        .grant               (grant),
        .busy                (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // client slots: 0=p0 wr, 1=p0 rd, 2=p1 wr, 3=p1 rd
    bit          c_req[4];
    bit          c_rand[4];
    int          c_todo[4];
    int          c_raise[4];
    logic [AW-1:0] c_addr[4], c_faddr[4];
    logic [BW-1:0] c_len[4], c_flen[4];

    // controller emulation
    bit k_active, k_wr, k_done, k_spur_force;
    int k_left, k_delay, k_spur_pct;

    // last observed DUT outputs (used only to steer stimulus)
    bit            o_wreq, o_rreq;
    logic [BW-1:0] o_wlen, o_rlen;
    logic [1:0]    o_wfin, o_rfin;

    // reference model
    bit m_burst, m_gap, m_zero;
    int m_slot, m_ptr;

    // logs for hand-computed expectations
    int         served_q[$];
    logic [1:0] grant_log[$];
    logic [1:0] prev_grant;
    int n_wdr[2], n_rdv[2], n_wfin[2], n_rfin[2];
    int n_gap, n_wreq, t_first_wreq, t_first_wfin1;

    int e3_order[2] = '{0, 3};
    int e4_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget exhausted at cycle %0d", name, cyc);
    endtask

    task automatic clear_logs();
        served_q.delete();
        grant_log.delete();
        for (int p = 0; p < 2; p++) begin
            n_wdr[p] = 0; n_rdv[p] = 0; n_wfin[p] = 0; n_rfin[p] = 0;
        end
        n_gap = 0; n_wreq = 0; t_first_wreq = -1; t_first_wfin1 = -1;
    endtask

    task automatic model_reset();
        m_burst = 0; m_gap = 0; m_zero = 0; m_slot = 0; m_ptr = 0;
        k_active = 0; k_done = 0; k_spur_force = 0;
        o_wreq = 0; o_rreq = 0; o_wlen = '0; o_rlen = '0; o_wfin = '0; o_rfin = '0;
        prev_grant = '0;
    endtask

    task automatic drive_inputs();
        wr_burst_data_req = 0; rd_burst_data_valid = 0;
        wr_burst_finish = 0; rd_burst_finish = 0;
        rd_burst_data = DQ'($urandom);
        if (k_done && !o_wreq && !o_rreq) k_done = 0;
        if (!k_active && !k_done && (o_wreq || o_rreq)) begin
            k_active = 1;
            k_wr = o_wreq;
            k_left = o_wreq ? int'(o_wlen) : int'(o_rlen);
            k_delay = $urandom_range(0, 2);
        end
        if (k_active) begin
            if (k_delay > 0) k_delay--;
            else if (k_left > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    if (k_wr) wr_burst_data_req = 1; else rd_burst_data_valid = 1;
                    k_left--;
                end
            end else begin
                if (k_wr) wr_burst_finish = 1; else rd_burst_finish = 1;
                k_active = 0;
                k_done = 1;
            end
            if (k_active && (k_spur_force || $urandom_range(0, 99) < k_spur_pct)) begin
                if (k_wr) rd_burst_finish = 1; else wr_burst_finish = 1;
                k_spur_force = 0;
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (c_req[s]) begin
                if ((s % 2 == 1) ? o_rfin[s/2] : o_wfin[s/2]) c_req[s] = 0;
            end else if (c_todo[s] > 0 && (!c_rand[s] || $urandom_range(0, 2) == 0)) begin
                c_req[s] = 1;
                c_todo[s]--;
                c_raise[s] = cyc;
                if (c_rand[s]) begin
                    c_addr[s] = AW'($urandom);
                    c_len[s]  = BW'($urandom_range(0, 12));
                end else begin
                    c_addr[s] = c_faddr[s];
                    c_len[s]  = c_flen[s];
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            p_wr_req[p] = c_req[2*p];
            p_rd_req[p] = c_req[2*p+1];
            p_wr_addr[p*AW +: AW] = c_addr[2*p];
            p_rd_addr[p*AW +: AW] = c_addr[2*p+1];
            p_wr_len[p*BW +: BW]  = c_len[2*p];
            p_rd_len[p*BW +: BW]  = c_len[2*p+1];
            p_wr_data[p*DQ +: DQ] = DQ'($urandom);
        end
    endtask

    task automatic sample_check();
        int         mport;
        bit         mrd, ebusy, ewreq, erreq;
        logic [1:0] one;
        mport = m_slot / 2;
        mrd   = (m_slot % 2) == 1;
        one   = (mport == 1) ? 2'b10 : 2'b01;
        ebusy = m_burst || m_gap;
        ewreq = m_burst && !mrd;
        erreq = m_burst && mrd;
        chk("busy", busy, ebusy);
        chk("grant", grant, ebusy ? one : 2'b00);
        chk("wr_burst_req", wr_burst_req, ewreq);
        chk("rd_burst_req", rd_burst_req, erreq);
        if (ewreq) begin
            chk("wr_burst_addr", wr_burst_addr, c_addr[m_slot]);
            chk("wr_burst_len", wr_burst_len, c_len[m_slot]);
            chk("wr_burst_data", wr_burst_data, p_wr_data[mport*DQ +: DQ]);
        end
        if (erreq) begin
            chk("rd_burst_addr", rd_burst_addr, c_addr[m_slot]);
            chk("rd_burst_len", rd_burst_len, c_len[m_slot]);
        end
        chk("p_wr_data_req", p_wr_data_req, (ewreq && wr_burst_data_req) ? one : 2'b00);
        chk("p_rd_data_valid", p_rd_data_valid, (erreq && rd_burst_data_valid) ? one : 2'b00);
        if (p_rd_data_valid != 0) chk("p_rd_data", p_rd_data, rd_burst_data);
        chk("p_wr_finish", p_wr_finish,
            ((ewreq && wr_burst_finish) || (m_gap && m_zero && !mrd)) ? one : 2'b00);
        chk("p_rd_finish", p_rd_finish,
            ((erreq && rd_burst_finish) || (m_gap && m_zero && mrd)) ? one : 2'b00);

        o_wreq = wr_burst_req; o_rreq = rd_burst_req;
        o_wlen = wr_burst_len; o_rlen = rd_burst_len;
        o_wfin = p_wr_finish;  o_rfin = p_rd_finish;
        for (int p = 0; p < 2; p++) begin
            n_wdr[p]  += int'(p_wr_data_req[p]);
            n_rdv[p]  += int'(p_rd_data_valid[p]);
            n_wfin[p] += int'(p_wr_finish[p]);
            n_rfin[p] += int'(p_rd_finish[p]);
            if (p_wr_finish[p]) served_q.push_back(2*p);
            if (p_rd_finish[p]) served_q.push_back(2*p+1);
        end
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
        prev_grant = grant;
        if (busy && !wr_burst_req && !rd_burst_req) n_gap++;
        if (wr_burst_req) n_wreq++;
        if (wr_burst_req && t_first_wreq < 0) t_first_wreq = cyc;
        if (p_wr_finish[1] && t_first_wfin1 < 0) t_first_wfin1 = cyc;
    endtask

    // One burst per grant, pointer moves past the served slot, one idle-free gap cycle.
    task automatic model_step();
        bit mrd;
        mrd = (m_slot % 2) == 1;
        if (m_burst) begin
            if (mrd ? rd_burst_finish : wr_burst_finish) begin
                m_burst = 0; m_gap = 1; m_zero = 0;
                m_ptr = (m_slot + 1) % 4;
            end
        end else if (m_gap) begin
            m_gap = 0; m_zero = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (c_req[s]) begin
                    m_slot = s;
                    if (c_len[s] == 0) begin
                        m_gap = 1; m_zero = 1; m_ptr = (s + 1) % 4;
                    end else begin
                        m_burst = 1;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_inputs();
        #1;
        sample_check();
        @(posedge clk);
        model_step();
        cyc++;
    endtask

    function automatic bit all_quiet();
        bit q;
        q = !m_burst && !m_gap && !k_active && !k_done;
        for (int s = 0; s < 4; s++) if (c_req[s] || c_todo[s] > 0) q = 0;
        return q;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!all_quiet() && n < budget) begin
            cycle();
            n++;
        end
        if (!all_quiet()) timeout_fail(name);
        repeat (2) cycle();
    endtask

    task automatic set_slot(input int s, input int todo, input logic [AW-1:0] a, input logic [BW-1:0] l);
        c_todo[s] = todo; c_faddr[s] = a; c_flen[s] = l; c_rand[s] = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wreq"}, wr_burst_req, 1'b0);
        chk({tag, "_rreq"}, rd_burst_req, 1'b0);
        chk({tag, "_strobes"}, {p_wr_data_req, p_wr_finish, p_rd_data_valid, p_rd_finish}, 8'h00);
        chk({tag, "_rd_data"}, p_rd_data, '0);
    endtask

    initial begin
        int seen;
        int n;
        rst = 1;
        p_wr_req = '0; p_rd_req = '0; p_wr_addr = '0; p_rd_addr = '0;
        p_wr_len = '0; p_rd_len = '0; p_wr_data = '0;
        wr_burst_data_req = 0; wr_burst_finish = 0;
        rd_burst_data = '0; rd_burst_data_valid = 0; rd_burst_finish = 0;
        k_spur_pct = 0;
        for (int s = 0; s < 4; s++) begin
            c_req[s] = 0; c_rand[s] = 0; c_todo[s] = 0; c_raise[s] = 0;
            c_addr[s] = '0; c_faddr[s] = '0; c_len[s] = '0; c_flen[s] = '0;
        end
        model_reset();
        clear_logs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 0;

        // p0 write and p1 read together from pointer 0
        clear_logs();
        set_slot(0, 1, 24'h000200, 10'd3);
        set_slot(3, 1, 24'h010020, 10'd4);
        run_until_idle("t_dual", 200);
        chk("t_dual_count", served_q.size(), 2);
        for (int i = 0; i < 2 && i < served_q.size(); i++) chk("t_dual_order", served_q[i], e3_order[i]);
        chk("t_dual_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t_dual_grant0", grant_log[0], 2'b01);
            chk("t_dual_grant1", grant_log[1], 2'b10);
        end
        chk("t_dual_rdv1", n_rdv[1], 4);
        chk("t_dual_rdv0", n_rdv[0], 0);

        // all four slots requesting: strict rotation
        clear_logs();
        set_slot(0, 2, 24'h000300, 10'd3);
        set_slot(1, 2, 24'h000400, 10'd2);
        set_slot(2, 2, 24'h000500, 10'd3);
        set_slot(3, 2, 24'h000600, 10'd2);
        run_until_idle("t_rot", 500);
        chk("t_rot_count", served_q.size(), 8);
        for (int i = 0; i < 8 && i < served_q.size(); i++) chk("t_rot_order", served_q[i], e4_order[i]);
        chk("t_rot_gaps", n_gap, 8);

        // single p0 write, length 8
        clear_logs();
        set_slot(0, 1, 24'h000100, 10'd8);
        run_until_idle("t_single", 200);
        chk("t_single_latency", t_first_wreq - c_raise[0], 1);
        chk("t_single_wdr0", n_wdr[0], 8);
        chk("t_single_wdr1", n_wdr[1], 0);
        chk("t_single_fin0", n_wfin[0], 1);
        chk("t_single_fin1", n_wfin[1] + n_rfin[0] + n_rfin[1], 0);

        // zero-length p1 write
        clear_logs();
        set_slot(2, 1, 24'h000700, 10'd0);
        run_until_idle("t_zero", 100);
        chk("t_zero_latency", t_first_wfin1 - c_raise[2], 1);
        chk("t_zero_fin1", n_wfin[1], 1);
        chk("t_zero_wreq", n_wreq, 0);

        // spurious write finish during a p0 read
        clear_logs();
        set_slot(1, 1, 24'h000800, 10'd5);
        k_spur_force = 1;
        run_until_idle("t_spur", 200);
        chk("t_spur_rfin0", n_rfin[0], 1);
        chk("t_spur_wfin", n_wfin[0] + n_wfin[1], 0);
        chk("t_spur_rdv0", n_rdv[0], 5);

        // reset in the middle of a length-16 p1 read
        clear_logs();
        set_slot(3, 1, 24'h0ABCDE, 10'd16);
        seen = 0;
        n = 0;
        while (seen < 3 && n < 40) begin
            cycle();
            if (o_rreq) seen++;
            n++;
        end
        if (seen < 3) timeout_fail("t_rst_wait");
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk_reset_outputs("t_rst_async");
        for (int s = 0; s < 4; s++) begin
            c_req[s] = 0; c_todo[s] = 0;
        end
        p_wr_req = '0; p_rd_req = '0;
        wr_burst_data_req = 0; wr_burst_finish = 0;
        rd_burst_data_valid = 0; rd_burst_finish = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        clear_logs();
        set_slot(0, 1, 24'h000900, 10'd2);
        set_slot(2, 1, 24'h000A00, 10'd2);
        run_until_idle("t_rst_after", 200);
        chk("t_rst_count", served_q.size(), 2);
        if (served_q.size() > 0) chk("t_rst_first", served_q[0], 0);
        chk("t_rst_rfin", n_rfin[0] + n_rfin[1], 0);

        // random traffic with occasional wrong-type finishes
        clear_logs();
        k_spur_pct = 5;
        for (int s = 0; s < 4; s++) begin
            c_rand[s] = 1;
            c_todo[s] = 10;
        end
        run_until_idle("t_rand", 6000);
        chk("t_rand_count", served_q.size(), 40);
        for (int s = 0; s < 4; s++) begin
            int cnt;
            cnt = 0;
            foreach (served_q[i]) if (served_q[i] == s) cnt++;
            chk("t_rand_per_slot", cnt, 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
